// File: rtl/act_mem_reader.sv
// act_mem_reader: streams a contiguous window of output_memory out on a
// valid/ready interface. A 3-entry FIFO with a registered head absorbs the
// memory's 1-cycle read latency so one word per cycle is sustained.
module act_mem_reader #(
   parameter int W      = 32,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [LEN_W-1:0]         len,
   output logic                     mem_rd_en,
   output logic [ADDR_W-1:0]        mem_rd_addr,
   input  logic signed [W-1:0]      mem_rd_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [W-1:0]      out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

   state_t                 state;
   state_t                 state_next;

   logic [ADDR_W-1:0]      addr;        // next read address
   logic [LEN_W-1:0]       remaining;   // reads still to issue
   logic [LEN_W-1:0]       len_q;       // transfer length
   logic [LEN_W-1:0]       beats;       // words handed downstream
   logic                   inflight;    // read data arrives this cycle

   logic [1:0]             fifo_count;
   logic signed [W-1:0]    entries [3]; // entries[0] is the head
   logic [2:0]             occupancy;
   logic [1:0]             wr_idx;
   logic                   issue;
   logic                   push;
   logic                   pop;

   // Issue only while the FIFO plus the pending response leave room; both
   // terms are registers, so out_ready never reaches mem_rd_en.
   assign occupancy   = 3'(fifo_count) + 3'(inflight);
   assign issue       = (state == READ) && (occupancy < 3'd3);
   assign push        = inflight;
   assign out_valid   = (fifo_count != 2'd0);
   assign out_data    = entries[0];
   assign pop         = out_valid && out_ready;
   assign out_last    = out_valid && (beats == len_q - LEN_W'(1));
   assign mem_rd_addr = addr;
   assign wr_idx      = fifo_count - 2'(pop);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and control outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves one unassigned (which would infer a latch).
      state_next = state;
      mem_rd_en  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = (len != '0) ? READ : DONE;
         end
         READ: begin
            busy      = 1'b1;
            mem_rd_en = issue;
            if (issue && (remaining == LEN_W'(1))) state_next = FLUSH;
         end
         FLUSH: begin
            busy = 1'b1;
            if (pop && out_last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Address, issue and beat counters plus the in-flight flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr      <= '0;
         remaining <= '0;
         len_q     <= '0;
         beats     <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= issue;
         if ((state == IDLE) && start) begin
            addr      <= base_addr;
            remaining <= len;
            len_q     <= len;
            beats     <= '0;
         end else begin
            if (issue) begin
               addr      <= addr + ADDR_W'(1);
               remaining <= remaining - LEN_W'(1);
            end
            if (pop) beats <= beats + LEN_W'(1);
         end
      end
   end

   // Shift FIFO: pops move entries toward the head, pushes land behind the
   // last word that survives this cycle's pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_count <= 2'd0;
         // NOTE: the three storage words are reset too, so out_data reads 0
         // after reset instead of a stale word.
         entries    <= '{default: '0};
      end else begin
         fifo_count <= fifo_count + 2'(push) - 2'(pop);
         if (pop) begin
            entries[0] <= entries[1];
            entries[1] <= entries[2];
         end
         // NOTE: with non-blocking assignments the push below overrides the
         // shift above when both target the same slot, which is the intent.
         if (push) begin
            case (wr_idx)
               2'd0:    entries[0] <= mem_rd_data;
               2'd1:    entries[1] <= mem_rd_data;
               2'd2:    entries[2] <= mem_rd_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_act_mem_reader.sv
// Testbench for act_mem_reader: random memory contents, a synchronous-read
// memory model, a scoreboard of expected addresses and words, and a monitor
// that compares whenever the DUT issues a read or presents a word.
module tb_act_mem_reader;

   localparam int W      = 32;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [ADDR_W-1:0]     base_addr;
   logic [LEN_W-1:0]      len;
   logic                  mem_rd_en;
   logic [ADDR_W-1:0]     mem_rd_addr;
   logic signed [W-1:0]   mem_rd_data;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic signed [W-1:0]   out_data;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   logic [W-1:0]          mem [DEPTH];
   logic [ADDR_W-1:0]     addr_q [$];
   beat_t                 data_q [$];

   int                    checks = 0;
   int                    errors = 0;
   int                    issued = 0;
   int                    popped = 0;
   bit                    prev_stall = 0;
   logic [W-1:0]          prev_data = '0;

   int                    cyc = 0;
   int                    hold_start = -100;
   bit                    ready_random = 0;

   act_mem_reader #(.W(W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .len         (len),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // output_memory model: synchronous read, data valid the cycle after the strobe
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   // Downstream acceptance: always ready, random, or a forced 5-cycle stall
   always @(posedge clk) begin
      cyc++;
      #1;
      if (cyc >= hold_start && cyc < hold_start + 5) out_ready = 1'b0;
      else if (ready_random)                          out_ready = ($urandom_range(0, 99) < 60);
      else                                            out_ready = 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares read addresses and delivered words against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         addr_q.delete();
         data_q.delete();
         issued     = 0;
         popped     = 0;
         prev_stall = 0;
      end else begin
         check("occupancy_le_3", 64'((issued - popped) <= 3), 64'd1);
         if (mem_rd_en) begin
            check("rd_expected", 64'(addr_q.size() != 0), 64'd1);
            if (addr_q.size() != 0) check("rd_addr", 64'(mem_rd_addr), 64'(addr_q.pop_front()));
            issued++;
         end
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'($unsigned(out_data)), 64'(prev_data));
         end
         if (out_valid) begin
            check("word_expected", 64'(data_q.size() != 0), 64'd1);
            if (data_q.size() != 0) begin
               check("out_data", 64'($unsigned(out_data)), 64'(data_q[0].data));
               check("out_last", 64'(out_last), 64'(data_q[0].last));
               if (out_ready) void'(data_q.pop_front());
            end
            if (out_ready) popped++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = $unsigned(out_data);
      end
   end

   // Issue a start and record the expected reads and words
   task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
      logic [ADDR_W-1:0] a;
      beat_t             e;
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = b;
      len       = n;
      for (int i = 0; i < int'(n); i++) begin
         a      = ADDR_W'((int'(b) + i) % DEPTH);
         e.data = mem[a];
         e.last = (i == int'(n) - 1);
         addr_q.push_back(a);
         data_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Returns at the negedge of the done cycle, or after the budget runs out
   task automatic wait_done(input int budget, output bit seen);
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      if (seen) begin
         check("busy_low_at_done", 64'(busy), 64'd0);
         check("words_left", 64'(data_q.size()), 64'd0);
         check("reads_left", 64'(addr_q.size()), 64'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_en"},   64'(mem_rd_en),             64'd0);
      check({tag, "_rd_addr"}, 64'(mem_rd_addr),           64'd0);
      check({tag, "_valid"},   64'(out_valid),             64'd0);
      check({tag, "_data"},    64'($unsigned(out_data)),   64'd0);
      check({tag, "_last"},    64'(out_last),              64'd0);
      check({tag, "_busy"},    64'(busy),                  64'd0);
      check({tag, "_done"},    64'(done),                  64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic transfer with exact cycle timing (cycle 1 is the first after start)
      start_xfer(10'h010, 11'd4);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         check($sformatf("basic_c%0d_rd_en", c), 64'(mem_rd_en), 64'(c >= 1 && c <= 4));
         check($sformatf("basic_c%0d_valid", c), 64'(out_valid), 64'(c >= 3 && c <= 6));
         check($sformatf("basic_c%0d_last", c),  64'(out_last),  64'(c == 6));
         check($sformatf("basic_c%0d_done", c),  64'(done),      64'(c == 7));
         check($sformatf("basic_c%0d_busy", c),  64'(busy),      64'(c >= 1 && c <= 6));
      end
      check("basic_words_left", 64'(data_q.size()), 64'd0);

      // Zero length: done in cycle 1, no reads, no words
      start_xfer(10'h055, 11'd0);
      @(negedge clk);
      check("zero_done",  64'(done),      64'd1);
      check("zero_rd_en", 64'(mem_rd_en), 64'd0);
      check("zero_valid", 64'(out_valid), 64'd0);
      check("zero_busy",  64'(busy),      64'd0);
      @(negedge clk);
      check("zero_done_once", 64'(done), 64'd0);

      // Address wrap at the top of memory
      start_xfer(10'd1022, 11'd4);
      wait_done(50, seen);

      // Backpressure: random ready plus 5 consecutive stalled cycles
      ready_random = 1;
      start_xfer(10'($urandom_range(0, DEPTH - 1)), 11'd8);
      hold_start = cyc + 2;
      wait_done(300, seen);

      // Randomized transfers under random backpressure
      for (int t = 0; t < 6; t++) begin
         start_xfer(10'($urandom_range(0, DEPTH - 1)), 11'($urandom_range(1, 40)));
         wait_done(1000, seen);
      end
      ready_random = 0;

      // Reset in cycle 4 of a 16-word transfer
      start_xfer(10'h200, 11'd16);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("midrst_no_done",  64'(done),      64'd0);
         check("midrst_no_valid", 64'(out_valid), 64'd0);
      end
      start_xfer(10'h3A0, 11'd5);
      wait_done(50, seen);

      // Starts during READ and during DONE are ignored
      start_xfer(10'h020, 11'd6);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'h100; len = 11'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(50, seen);
      if (seen) begin
         start = 1'b1; base_addr = 10'h100; len = 11'd3;
         @(posedge clk); #1;
         start = 1'b0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("ign_idle_busy",  64'(busy),      64'd0);
            check("ign_idle_rd_en", 64'(mem_rd_en), 64'd0);
         end
      end

      // Maximum length: covers the whole memory and wraps
      start_xfer(10'($urandom_range(0, DEPTH - 1)), 11'd2047);
      wait_done(2200, seen);

      repeat (3) @(negedge clk);
      check("final_words_left", 64'(data_q.size()), 64'd0);
      check("final_reads_left", 64'(addr_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/act_mem_reader.md
# act_mem_reader

Streaming read-back engine for the activation output memory. After the post-processing stage has written quantized or ReLU-activated words into output_memory, this block reads a programmed contiguous window from that memory's synchronous read port and emits the words on a valid/ready stream toward the next layer's input buffer or the host DMA. A small internal FIFO absorbs the memory's 1-cycle read latency, so the block sustains one word per cycle under continuous `out_ready` and loses nothing under backpressure.

## Interface
Parameters:
- W, 32, data word width; matches the post-processing data bus.
- ADDR_W, 10, output_memory address width.
- LEN_W, 11, width of the transfer-length field.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- len  in  LEN_W  number of words to read; sampled with start.
- mem_rd_en  out  1  read strobe to output_memory.
- mem_rd_addr  out  ADDR_W  read address; meaningful only while mem_rd_en=1.
- mem_rd_data  in  signed W  read data, valid in the cycle after mem_rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  signed W  stream data.
- out_last  out  1  high with the final word of the transfer.
- busy  out  1  high in READ or FLUSH.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE:
  - On start=1 with len>0, latch base_addr and len into the address and remaining-issue counters, then go to READ.
  - On start=1 with len=0, go directly to DONE; no memory reads are issued.
- READ:
  - mem_rd_en=1 when (fifo_count + inflight) < 3.
  - mem_rd_addr = current address. The address increments by 1 per issue and wraps modulo 2^ADDR_W.
  - When the last read is issued, go to FLUSH.
- inflight: 1-bit flag, set in the cycle after an issue. When inflight=1, mem_rd_data is pushed into the FIFO.
- FIFO:
  - 3 entries; the head is registered.
  - out_valid = (fifo_count > 0); out_data = head.
  - A word pops on out_valid && out_ready.
  - A push and a pop may occur in the same cycle; the count is unchanged.
  - The issue rule guarantees the FIFO never overflows.
- Beat counter: counts popped words. out_last = out_valid && (beats_popped == len-1).
- FLUSH: no issues. After the handshake of the last word, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored, including in the DONE cycle.
- out_data is held stable while out_valid=1 && out_ready=0.

## Timing
- Reset values: mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Internally: state=IDLE, FIFO empty, inflight=0, all counters 0.
- Latency, with start sampled at the end of cycle 0:
  - Cycle 1: READ; first mem_rd_en.
  - Cycle 2: mem_rd_data captured.
  - Cycle 3: first out_valid.
- Throughput: 1 word/cycle while out_ready=1. Steady state is fifo_count=1, inflight=1.
- There is no combinational path from out_ready to mem_rd_en.
- Completion: done asserts in the cycle after the last handshake. busy falls in that same cycle.
- Reset mid-transfer: within one cycle, return to IDLE with the FIFO emptied. A read response arriving in the cycle after rst is discarded (inflight was cleared), and done is not pulsed.
- len maximum is 2^LEN_W − 1. A transfer may cover the whole memory, wrapping around.

## Test plan
- Basic transfer: base=0x010, len=4, out_ready=1.
  - mem_rd_en in cycles 1–4 with addresses 0x010..0x013.
  - out_valid in cycles 3–6, data matching memory contents.
  - out_last only in cycle 6; done in cycle 7; busy high in cycles 1–6.
- Backpressure: len=8 with out_ready toggled pseudo-randomly (including 5 consecutive low cycles).
  - All 8 words delivered, in order, none duplicated.
  - fifo_count + inflight never exceeds 3.
  - out_data stable while stalled.
- Wrap: ADDR_W=4, base=14, len=4 → read addresses 14, 15, 0, 1; out_last on the 4th word.
- Zero length: start with len=0 → no mem_rd_en, no out_valid, done in cycle 1.
- Reset mid-operation: assert rst in cycle 4 of a len=16 transfer.
  - Next cycle: all outputs at reset values; no done pulse.
  - A fresh start then reads from the new base correctly.
- Ignored start: pulse start with base=0x100 during READ and again during DONE → both ignored; the original transfer's addresses and count are unaffected.
